// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a combinational-read ROM; registers the returned word.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module rom_read_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    output logic                  o_gnt0,
    output logic                  o_rvalid0,
    input  logic                  i_req1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    output logic                  o_gnt1,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_addr_r,
    input  logic [DATA_WIDTH-1:0] i_q_r
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  r_owner;
    logic [CNT_W-1:0]      r_cnt;
`ifndef ROM_ARB_FIXED_PRIO_EN
    logic                  r_last;
`endif

    logic                  w_gnt0;
    logic                  w_gnt1;

    // Grant decision: only in IDLE, at most one winner
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            if (i_req0) begin
                w_gnt0 = 1'b1;
            end else if (i_req1) begin
                w_gnt1 = 1'b1;
            end
`else
            if (i_req0 && i_req1) begin
                // Tie goes to the port that was not served last
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else if (i_req0) begin
                w_gnt0 = 1'b1;
            end else if (i_req1) begin
                w_gnt1 = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_owner   <= 1'b0;
            r_cnt     <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
            r_last    <= 1'b1;
`endif
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_addr  <= w_gnt1 ? i_addr1 : i_addr0;
                        r_owner <= w_gnt1;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_rdata   <= i_q_r;
                        r_rvalid0 <= ~r_owner;
                        r_rvalid1 <= r_owner;
`ifndef ROM_ARB_FIXED_PRIO_EN
                        r_last    <= r_owner;
`endif
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt0    = w_gnt0;
    assign o_gnt1    = w_gnt1;
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata   = r_rdata;
    assign o_busy    = (r_state == READ);
    assign o_addr_r  = r_addr;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: one instance with no wait states, one with two.
module tb_rom_read_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    int            checks;
    int            errors;

    // Instance a: WAIT_CYCLES = 0
    logic          rst_n_a, req0_a, req1_a;
    logic [AW-1:0] addr0_a, addr1_a, addr_r_a;
    logic          gnt0_a, gnt1_a, rv0_a, rv1_a, busy_a;
    logic [DW-1:0] rdata_a, q_a;
    logic [4:0]    st_a;

    // Instance b: WAIT_CYCLES = 2
    logic          rst_n_b, req0_b, req1_b;
    logic [AW-1:0] addr0_b, addr1_b, addr_r_b;
    logic          gnt0_b, gnt1_b, rv0_b, rv1_b, busy_b;
    logic [DW-1:0] rdata_b, q_b;
    logic [4:0]    st_b;

    assign q_a  = 32'hA000_0000 + 32'(addr_r_a);
    assign q_b  = 32'hA000_0000 + 32'(addr_r_b);
    assign st_a = {gnt0_a, gnt1_a, busy_a, rv0_a, rv1_a};
    assign st_b = {gnt0_b, gnt1_b, busy_b, rv0_b, rv1_b};

    rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n_a),
        .i_req0(req0_a), .i_addr0(addr0_a), .o_gnt0(gnt0_a), .o_rvalid0(rv0_a),
        .i_req1(req1_a), .i_addr1(addr1_a), .o_gnt1(gnt1_a), .o_rvalid1(rv1_a),
        .o_rdata(rdata_a), .o_busy(busy_a), .o_addr_r(addr_r_a), .i_q_r(q_a)
    );

    rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n_b),
        .i_req0(req0_b), .i_addr0(addr0_b), .o_gnt0(gnt0_b), .o_rvalid0(rv0_b),
        .i_req1(req1_b), .i_addr1(addr1_b), .o_gnt1(gnt1_b), .o_rvalid1(rv1_b),
        .o_rdata(rdata_b), .o_busy(busy_b), .o_addr_r(addr_r_b), .i_q_r(q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status vectors are {gnt0, gnt1, busy, rvalid0, rvalid1}
    task automatic test_reset();
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        req0_a = 1'b0; req1_a = 1'b0; addr0_a = '0; addr1_a = '0;
        req0_b = 1'b0; req1_b = 1'b0; addr0_b = '0; addr1_b = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (st_a !== 5'b00000 || rdata_a !== 32'h0 || addr_r_a !== 10'd0) begin
            errors++;
            $display("FAIL reset_a st=%b rdata=%h addr=%0d exp st=00000 rdata=0 addr=0", st_a, rdata_a, addr_r_a);
        end
        checks++;
        if (st_b !== 5'b00000 || rdata_b !== 32'h0 || addr_r_b !== 10'd0) begin
            errors++;
            $display("FAIL reset_b st=%b rdata=%h addr=%0d exp st=00000 rdata=0 addr=0", st_b, rdata_b, addr_r_b);
        end
        @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
    endtask

    task automatic test_tie_rr();
        logic       exp_port;
        logic       prev_port;
        logic [4:0] exp_st;
        logic [DW-1:0] exp_data;
        prev_port = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req0_a = 1'b1; req1_a = 1'b1; addr0_a = 10'd3; addr1_a = 10'd9;
            #1;
`ifdef ROM_ARB_FIXED_PRIO_EN
            exp_port = 1'b0;
`else
            exp_port = 1'(k % 2);
`endif
            exp_st = {~exp_port, exp_port, 1'b0, (k > 0) && !prev_port, (k > 0) && prev_port};
            checks++;
            if (st_a !== exp_st) begin
                errors++;
                $display("FAIL tie_grant%0d st=%b exp=%b", k, st_a, exp_st);
            end
            if (k > 0) begin
                exp_data = prev_port ? 32'hA000_0009 : 32'hA000_0003;
                checks++;
                if (rdata_a !== exp_data) begin
                    errors++;
                    $display("FAIL tie_rdata%0d got=%h exp=%h", k, rdata_a, exp_data);
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (st_a !== 5'b00100 || addr_r_a !== (exp_port ? 10'd9 : 10'd3)) begin
                errors++;
                $display("FAIL tie_busy%0d st=%b addr=%0d exp st=00100 addr=%0d", k, st_a, addr_r_a, exp_port ? 9 : 3);
            end
            prev_port = exp_port;
        end
        // Port 0 drops: port 1 must win the very next IDLE cycle
        @(negedge clk);
        req0_a = 1'b0;
        #1;
        exp_st = {1'b0, 1'b1, 1'b0, !prev_port, prev_port};
        exp_data = prev_port ? 32'hA000_0009 : 32'hA000_0003;
        checks++;
        if (st_a !== exp_st || rdata_a !== exp_data) begin
            errors++;
            $display("FAIL tie_drop0 st=%b rdata=%h exp st=%b rdata=%h", st_a, rdata_a, exp_st, exp_data);
        end
        @(negedge clk);
        req1_a = 1'b0;
        #1;
        checks++;
        if (st_a !== 5'b00100) begin
            errors++;
            $display("FAIL tie_tail_busy st=%b exp=00100", st_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (st_a !== 5'b00001 || rdata_a !== 32'hA000_0009) begin
            errors++;
            $display("FAIL tie_tail_rvalid st=%b rdata=%h exp st=00001 rdata=a0000009", st_a, rdata_a);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_a = 1'b1; addr0_a = 10'd5;
        #1;
        checks++;
        if (st_a !== 5'b10000) begin
            errors++;
            $display("FAIL single_gnt st=%b exp=10000", st_a);
        end
        @(negedge clk);
        req0_a = 1'b0; addr0_a = 10'd77;
        #1;
        checks++;
        if (st_a !== 5'b00100 || addr_r_a !== 10'd5) begin
            errors++;
            $display("FAIL single_busy st=%b addr=%0d exp st=00100 addr=5", st_a, addr_r_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (st_a !== 5'b00010 || rdata_a !== 32'hA000_0005) begin
            errors++;
            $display("FAIL single_rvalid st=%b rdata=%h exp st=00010 rdata=a0000005", st_a, rdata_a);
        end
        @(negedge clk);
        #1;
        checks++;
        if (st_a !== 5'b00000 || rdata_a !== 32'hA000_0005) begin
            errors++;
            $display("FAIL single_hold st=%b rdata=%h exp st=00000 rdata=a0000005", st_a, rdata_a);
        end
    endtask

    task automatic test_retract();
        @(negedge clk);
        req0_a = 1'b1; addr0_a = 10'd2;
        #1;
        checks++;
        if (st_a !== 5'b10000) begin
            errors++;
            $display("FAIL retract_gnt0 st=%b exp=10000", st_a);
        end
        @(negedge clk);
        req0_a = 1'b0; req1_a = 1'b1; addr1_a = 10'd8;
        #1;
        checks++;
        if (st_a !== 5'b00100) begin
            errors++;
            $display("FAIL retract_pulse st=%b exp=00100", st_a);
        end
        @(negedge clk);
        req1_a = 1'b0;
        #1;
        checks++;
        if (st_a !== 5'b00010 || rdata_a !== 32'hA000_0002) begin
            errors++;
            $display("FAIL retract_rvalid0 st=%b rdata=%h exp st=00010 rdata=a0000002", st_a, rdata_a);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (st_a !== 5'b00000) begin
                errors++;
                $display("FAIL retract_quiet%0d st=%b exp=00000", k, st_a);
            end
        end
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        req1_b = 1'b1; addr1_b = 10'd7;
        #1;
        checks++;
        if (st_b !== 5'b01000) begin
            errors++;
            $display("FAIL wait_gnt1 st=%b exp=01000", st_b);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req1_b = 1'b0;
            #1;
            checks++;
            if (st_b !== 5'b00100 || addr_r_b !== 10'd7) begin
                errors++;
                $display("FAIL wait_busy%0d st=%b addr=%0d exp st=00100 addr=7", k, st_b, addr_r_b);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (st_b !== 5'b00001 || rdata_b !== 32'hA000_0007) begin
            errors++;
            $display("FAIL wait_rvalid1 st=%b rdata=%h exp st=00001 rdata=a0000007", st_b, rdata_b);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req0_b = 1'b1; addr0_b = 10'd4;
        #1;
        checks++;
        if (st_b !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_gnt0 st=%b exp=10000", st_b);
        end
        @(negedge clk);
        req0_b = 1'b0;
        #1;
        checks++;
        if (st_b !== 5'b00100 || addr_r_b !== 10'd4) begin
            errors++;
            $display("FAIL rstmid_busy st=%b addr=%0d exp st=00100 addr=4", st_b, addr_r_b);
        end
        rst_n_b = 1'b0;
        #1;
        checks++;
        if (st_b !== 5'b00000 || rdata_b !== 32'h0 || addr_r_b !== 10'd0) begin
            errors++;
            $display("FAIL rstmid_clear st=%b rdata=%h addr=%0d exp all zero", st_b, rdata_b, addr_r_b);
        end
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (st_b !== 5'b00000) begin
                errors++;
                $display("FAIL rstmid_norvalid%0d st=%b exp=00000", k, st_b);
            end
        end
        // Aborted access must not count as served: tie returns to port 0
        @(negedge clk);
        req0_b = 1'b1; req1_b = 1'b1; addr0_b = 10'd3; addr1_b = 10'd9;
        #1;
        checks++;
        if (st_b !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_tie st=%b exp=10000", st_b);
        end
        @(negedge clk);
        req0_b = 1'b0; req1_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (st_b !== 5'b00010 || rdata_b !== 32'hA000_0003) begin
            errors++;
            $display("FAIL rstmid_after st=%b rdata=%h exp st=00010 rdata=a0000003", st_b, rdata_b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_tie_rr();
        test_single();
        test_retract();
        test_wait_states();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
